// File: rtl/teak_action_ctrl_regs.sv
// -----------------------------------------------------------------------------
// teak_action_ctrl_regs
//   AXI-Lite control/parameter register block for a single Teak action.
//   Software writes PARAM registers, sets CTRL.start, and the block runs a
//   go/done four-phase handshake with the action. The action can fetch any
//   PARAM value through a request/acknowledge lookup channel at any time.
//
// Ports
//   clk, reset             : clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*        : AXI-Lite write address / data / response
//   s_axi_ar*/r*           : AXI-Lite read address / data
//   go_0r / go_0a          : action start request (out) / acknowledge (in)
//   done_0r / done_0a      : action completion request (in) / acknowledge (out)
//   paramaddr_0r0/_0D/_0a  : parameter index request, index, acknowledge
//   paramdata_0r0/_0D/_0a  : parameter value valid, value, acknowledge
//
// Register map (byte offsets, only addr[7:0] decoded)
//   0x00       CTRL  bit0 start (W1S, reads 1 while busy), bit1 done (sticky,
//                    cleared by a CTRL read), bit2 idle
//   0x10+4*i   PARAM[i], i < NUM_PARAMS (writes dropped while busy)
//   others     read 0, writes discarded; every response is OKAY
// -----------------------------------------------------------------------------
module teak_action_ctrl_regs #(
  parameter int unsigned NUM_PARAMS = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,

  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,

  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,

  input  logic        paramaddr_0r0,
  input  logic [31:0] paramaddr_0D,
  output logic        paramaddr_0a,
  output logic        paramdata_0r0,
  output logic [31:0] paramdata_0D,
  input  logic        paramdata_0a
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned OFF_W      = 8;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned MAX_PARAMS = 16;

  localparam logic [OFF_W-1:0] CTRL_OFF   = 8'h00;
  localparam logic [OFF_W-1:0] PARAM_BASE = 8'h10;
  localparam logic [1:0]       RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_RUN  = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic [DATA_W-1:0] params_w [MAX_PARAMS];

  logic [OFF_W-1:0] wr_off, wr_rel, rd_off, rd_rel;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_is_ctrl, wr_is_param, rd_is_ctrl, rd_is_param;
  logic             wr_fire, rd_fire, aw_accept, ar_accept, pa_accept;
  logic             start_req, param_wr_en, done_set, ctrl_rd;
  logic [DATA_W-1:0] rd_value, pd_value;

  // Upper address bits are intentionally not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[31:OFF_W], s_axi_araddr[31:OFF_W]};

  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;

  // Write address decode
  always_comb begin : wr_decode
    wr_off      = s_axi_awaddr[OFF_W-1:0];
    wr_rel      = wr_off - PARAM_BASE;
    wr_idx      = wr_rel[5:2];
    wr_is_ctrl  = (wr_off == CTRL_OFF);
    wr_is_param = (wr_off >= PARAM_BASE) && (wr_rel[1:0] == 2'b00) &&
                  (32'(wr_rel[7:2]) < NUM_PARAMS);
  end

  // Read address decode
  always_comb begin : rd_decode
    rd_off      = s_axi_araddr[OFF_W-1:0];
    rd_rel      = rd_off - PARAM_BASE;
    rd_idx      = rd_rel[5:2];
    rd_is_ctrl  = (rd_off == CTRL_OFF);
    rd_is_param = (rd_off >= PARAM_BASE) && (rd_rel[1:0] == 2'b00) &&
                  (32'(rd_rel[7:2]) < NUM_PARAMS);
  end

  // Handshake qualifiers; ready is a one-cycle pulse, so it is masked by itself
  always_comb begin : hs_logic
    aw_accept   = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
    wr_fire     = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
    ar_accept   = s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
    rd_fire     = s_axi_arready && s_axi_arvalid;
    pa_accept   = paramaddr_0r0 && !paramdata_0r0 && !paramaddr_0a;
    start_req   = wr_fire && wr_is_ctrl && s_axi_wdata[0] && s_axi_wstrb[0] &&
                  (state_q == ST_IDLE);
    param_wr_en = wr_fire && wr_is_param && (state_q == ST_IDLE);
    ctrl_rd     = rd_fire && rd_is_ctrl;
  end

  // Control FSM next state
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_req) state_d = ST_GO;
      ST_GO:   if (go_0a)     state_d = ST_RUN;
      ST_RUN:  if (done_0r)   state_d = ST_ACK;
      ST_ACK:                 state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Sticky done: set on ACK entry wins over a coincident CTRL-read clear
  always_comb begin : done_next
    done_set = (state_d == ST_ACK) && (state_q != ST_ACK);
    done_d   = done_q;
    if (done_set) begin
      done_d = 1'b1;
    end else if (ctrl_rd || start_req) begin
      done_d = 1'b0;
    end
  end

  // FSM state and its registered decodes
  always_ff @(posedge clk or negedge reset) begin : fsm_regs
    if (!reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      go_0r   <= 1'b0;
      done_0a <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      go_0r   <= (state_d == ST_GO);
      done_0a <= (state_d == ST_ACK);
    end
  end

  // PARAM storage; slots beyond NUM_PARAMS read as zero
  for (genvar k = 0; k < int'(MAX_PARAMS); k++) begin : g_param
    if (k < int'(NUM_PARAMS)) begin : g_reg
      logic [DATA_W-1:0] val_q;
      always_ff @(posedge clk or negedge reset) begin : param_reg
        if (!reset) begin
          val_q <= '0;
        end else if (param_wr_en && (wr_idx == IDX_W'(k))) begin
          for (int b = 0; b < int'(STRB_W); b++) begin
            if (s_axi_wstrb[b]) val_q[8*b +: 8] <= s_axi_wdata[8*b +: 8];
          end
        end
      end
      assign params_w[k] = val_q;
    end else begin : g_tie
      assign params_w[k] = '0;
    end
  end

  // AXI write channel
  always_ff @(posedge clk or negedge reset) begin : axi_wr
    if (!reset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      s_axi_awready <= aw_accept;
      s_axi_wready  <= aw_accept;
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read data mux
  always_comb begin : rd_mux
    rd_value = '0;
    if (rd_is_ctrl) begin
      rd_value[0] = (state_q != ST_IDLE);
      rd_value[1] = done_q;
      rd_value[2] = (state_q == ST_IDLE);
    end else if (rd_is_param) begin
      rd_value = params_w[rd_idx];
    end
  end

  // AXI read channel
  always_ff @(posedge clk or negedge reset) begin : axi_rd
    if (!reset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_arready <= ar_accept;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_value;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // Parameter lookup value; out-of-range index returns zero
  always_comb begin : pd_mux
    pd_value = '0;
    if (paramaddr_0D < NUM_PARAMS) pd_value = params_w[paramaddr_0D[IDX_W-1:0]];
  end

  // Parameter lookup channel
  always_ff @(posedge clk or negedge reset) begin : param_chan
    if (!reset) begin
      paramaddr_0a  <= 1'b0;
      paramdata_0r0 <= 1'b0;
      paramdata_0D  <= '0;
    end else begin
      paramaddr_0a <= pa_accept;
      if (paramaddr_0a) begin
        paramdata_0r0 <= 1'b1;
        paramdata_0D  <= pd_value;
      end else if (paramdata_0a) begin
        paramdata_0r0 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_teak_action_ctrl_regs.sv
module tb_teak_action_ctrl_regs;

  localparam int unsigned NP = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        go_0r;
  logic        go_0a = 1'b0;
  logic        done_0r = 1'b0;
  logic        done_0a;
  logic        paramaddr_0r0 = 1'b0;
  logic [31:0] paramaddr_0D = '0;
  logic        paramaddr_0a;
  logic        paramdata_0r0;
  logic [31:0] paramdata_0D;
  logic        paramdata_0a = 1'b0;

  teak_action_ctrl_regs #(.NUM_PARAMS(NP)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .paramaddr_0r0(paramaddr_0r0), .paramaddr_0D(paramaddr_0D), .paramaddr_0a(paramaddr_0a),
    .paramdata_0r0(paramdata_0r0), .paramdata_0D(paramdata_0D), .paramdata_0a(paramdata_0a)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents and software-visible action status
  logic [31:0] m_params [16];
  bit          m_busy;
  bit          m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int param_index(input logic [31:0] a);
    int off;
    off = int'(a[7:0]);
    if (off >= 16 && (off % 4) == 0 && (off - 16) / 4 < int'(NP)) return (off - 16) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] ctrl_value();
    return {29'd0, ~m_busy, m_done, m_busy};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = param_index(a);
    if (a[7:0] == 8'h00) begin
      if (d[0] && s[0] && !m_busy) begin
        m_busy = 1'b1;
        m_done = 1'b0;
      end
    end else if (idx >= 0 && !m_busy) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_params[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = param_index(a);
    if (a[7:0] == 8'h00) return ctrl_value();
    if (idx >= 0) return m_params[idx];
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_params[i] = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic aw_present(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
  endtask

  // Waits for the ready pulse, lets the transfer edge pass, drops valids
  task automatic aw_wait_fire();
    int n;
    n = 0;
    while (s_axi_awready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("awready_seen", 32'(s_axi_awready), 32'd1);
    check("wready_with_awready", 32'(s_axi_wready), 32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("awready_pulse", 32'(s_axi_awready), 32'd0);
  endtask

  task automatic b_accept();
    check("bvalid", 32'(s_axi_bvalid), 32'd1);
    check("bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_present(a, d, s);
    aw_wait_fire();
    b_accept();
    model_write(a, d, s);
  endtask

  task automatic ar_fire(input logic [31:0] a);
    int n;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("arready_seen", 32'(s_axi_arready), 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [31:0] a, output logic [31:0] got);
    logic [31:0] exp;
    exp = model_read(a);
    ar_fire(a);
    if (a[7:0] == 8'h00) m_done = 1'b0;
    check("rvalid", 32'(s_axi_rvalid), 32'd1);
    check("rresp", 32'(s_axi_rresp), 32'd0);
    check(tag, s_axi_rdata, exp);
    got = s_axi_rdata;
    tick();
    check("rdata_held", s_axi_rdata, exp);
    check("rvalid_held", 32'(s_axi_rvalid), 32'd1);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("rvalid_drop", 32'(s_axi_rvalid), 32'd0);
  endtask

  task automatic lookup(input logic [31:0] idx, input int hold);
    logic [31:0] exp;
    int n;
    exp = (idx < NP) ? m_params[idx[3:0]] : 32'd0;
    paramaddr_0D  = idx;
    paramaddr_0r0 = 1'b1;
    n = 0;
    while (paramaddr_0a !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("paramaddr_ack", 32'(paramaddr_0a), 32'd1);
    paramaddr_0r0 = 1'b0;
    tick();
    check("paramaddr_ack_pulse", 32'(paramaddr_0a), 32'd0);
    for (int i = 0; i < hold; i++) begin
      check("paramdata_valid_hold", 32'(paramdata_0r0), 32'd1);
      check("paramdata_value_hold", paramdata_0D, exp);
      tick();
    end
    check("paramdata_valid", 32'(paramdata_0r0), 32'd1);
    check("paramdata_value", paramdata_0D, exp);
    paramdata_0a = 1'b1;
    tick();
    paramdata_0a = 1'b0;
    check("paramdata_drop", 32'(paramdata_0r0), 32'd0);
  endtask

  logic [31:0] got;
  logic [31:0] r1, r2, a, d;
  logic [3:0]  s;
  logic [7:0]  off;
  int          kind;

  initial begin
    model_reset();

    // Reset state
    tick();
    tick();
    check("reset_ctl_outputs", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
          s_axi_rvalid, go_0r, done_0a, paramaddr_0a, paramdata_0r0}), 32'd0);
    check("reset_rdata", s_axi_rdata, 32'd0);
    check("reset_paramdata", paramdata_0D, 32'd0);
    reset = 1'b1;
    tick();
    axi_read("ctrl_after_reset", 32'h0, got);
    check("ctrl_after_reset_literal", got, 32'h4);

    // Partial strobe write
    axi_write(32'h18, 32'hDEADBEEF, 4'b0011);
    axi_read("param2_strobe", 32'h18, got);
    check("param2_strobe_literal", got, 32'h0000BEEF);

    // Unmapped offsets
    axi_read("unmapped_04", 32'h04, got);
    axi_write(32'h0C, 32'hFFFFFFFF, 4'hF);
    axi_read("unmapped_0c", 32'h0C, got);
    axi_read("param0_after_0c", 32'h10, got);

    // Randomized register traffic
    for (int i = 0; i < 60; i++) begin
      r1   = $urandom;
      r2   = $urandom;
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: off = 8'h10 + 8'($urandom_range(0, NP + 1) * 4);
        2:    off = r1[7:0];
        default: off = 8'h00;
      endcase
      a = {r2[31:8], off};
      d = $urandom;
      s = r1[11:8];
      if (off != 8'h00 && r1[12]) axi_write(a, d, s);
      else axi_read("rand_read", a, got);
    end
    for (int i = 0; i < int'(NP); i++) axi_read("param_sweep", 32'h10 + 32'(4 * i), got);

    // Parameter lookup channel, including out-of-range indices
    axi_write(32'h24, 32'h00001234, 4'hF);
    lookup(32'd5, 3);
    check("lookup5_literal", m_params[5], 32'h00001234);
    lookup(32'(NP), 1);
    lookup(32'hFFFF_0002, 0);
    for (int i = 0; i < 8; i++) lookup(32'($urandom_range(0, NP + 1)), $urandom_range(0, 3));

    // Action start / go / done sequence
    aw_present(32'h0, 32'h1, 4'h1);
    aw_wait_fire();
    model_write(32'h0, 32'h1, 4'h1);
    check("go_after_start", 32'(go_0r), 32'd1);
    b_accept();
    check("go_held", 32'(go_0r), 32'd1);
    axi_read("ctrl_in_go", 32'h0, got);
    axi_write(32'h10, 32'hA5A5A5A5, 4'hF);
    axi_write(32'h0, 32'h1, 4'h1);
    check("go_still_held", 32'(go_0r), 32'd1);
    go_0a = 1'b1;
    tick();
    go_0a = 1'b0;
    check("go_drop_in_run", 32'(go_0r), 32'd0);
    axi_read("ctrl_in_run", 32'h0, got);
    lookup(32'd2, 1);
    axi_read("param0_unchanged_busy", 32'h10, got);
    done_0r = 1'b1;
    tick();
    done_0r = 1'b0;
    m_done = 1'b1;
    check("done_ack", 32'(done_0a), 32'd1);
    tick();
    m_busy = 1'b0;
    check("done_ack_one_cycle", 32'(done_0a), 32'd0);
    axi_read("ctrl_done", 32'h0, got);
    check("ctrl_done_literal", got, 32'h6);
    axi_read("ctrl_done_cleared", 32'h0, got);
    check("ctrl_done_cleared_literal", got, 32'h4);

    // Write response back-pressure with a second write pending
    aw_present(32'h14, 32'h11112222, 4'hF);
    aw_wait_fire();
    model_write(32'h14, 32'h11112222, 4'hF);
    aw_present(32'h1C, 32'h33334444, 4'hC);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid_held", 32'(s_axi_bvalid), 32'd1);
      check("bp_awready_low", 32'({s_axi_awready, s_axi_wready}), 32'd0);
      tick();
    end
    b_accept();
    check("bp_awready_low_after_b", 32'(s_axi_awready), 32'd0);
    aw_wait_fire();
    b_accept();
    model_write(32'h1C, 32'h33334444, 4'hC);
    axi_read("bp_first", 32'h14, got);
    axi_read("bp_second", 32'h1C, got);

    // Reset while RUN with read data pending
    axi_write(32'h0, 32'h1, 4'h1);
    go_0a = 1'b1;
    tick();
    go_0a = 1'b0;
    ar_fire(32'h0);
    check("pre_reset_rvalid", 32'(s_axi_rvalid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_ctl_outputs", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
          s_axi_rvalid, go_0r, done_0a, paramaddr_0a, paramdata_0r0}), 32'd0);
    check("mid_reset_rdata", s_axi_rdata, 32'd0);
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_no_resp", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
    end
    axi_read("ctrl_after_mid_reset", 32'h0, got);
    check("ctrl_after_mid_reset_literal", got, 32'h4);
    axi_read("param2_after_mid_reset", 32'h18, got);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/teak_action_ctrl_regs.md
TEAK_ACTION_CTRL_REGS -- requirements
Module: teak_action_ctrl_regs

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_PARAMS, default 8, SHALL set the number of 32-bit parameter registers (range 1-16).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 s_axi_awaddr/awvalid/awready  in/in/out  32/1/1  AXI-Lite write address.
REQ-006 s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  AXI-Lite write data.
REQ-007 s_axi_bresp/bvalid/bready  out/out/in  2/1/1  AXI-Lite write response.
REQ-008 s_axi_araddr/arvalid/arready  in/in/out  32/1/1  AXI-Lite read address.
REQ-009 s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  AXI-Lite read data.
REQ-010 go_0r out 1, go_0a in 1  action start request/acknowledge.
REQ-011 done_0r in 1, done_0a out 1  action completion request/acknowledge.
REQ-012 paramaddr_0r0 in 1, paramaddr_0D in 32, paramaddr_0a out 1  parameter index from action.
REQ-013 paramdata_0r0 out 1, paramdata_0D out 32, paramdata_0a in 1  parameter value to action.

Function
REQ-014 Register map SHALL be: 0x00 CTRL (bit0 start W1S, bit1 done sticky RO, bit2 idle RO); 0x10+4*i PARAM[i], i<NUM_PARAMS; all other offsets read 0, writes discarded; only awaddr[7:0]/araddr[7:0] decoded.
REQ-015 Every response SHALL be OKAY (bresp=rresp=2'b00).
REQ-016 Write: awready and wready SHALL pulse together for one cycle only when awvalid&wvalid&!bvalid; register update on that cycle, honouring wstrb per byte; bvalid asserted next cycle, held until bready sampled high.
REQ-017 Read: arready SHALL pulse one cycle when arvalid&!rvalid; rdata registered and rvalid asserted next cycle; rdata/rvalid held stable until rready sampled high.
REQ-018 Control FSM states IDLE, GO, RUN, ACK; IDLE->GO on CTRL write with wdata[0]=1 and wstrb[0]=1; GO->RUN on go_0a=1; RUN->ACK on done_0r=1; ACK->IDLE after exactly one cycle.
REQ-019 go_0r SHALL equal (state==GO); done_0a SHALL equal (state==ACK); CTRL.idle SHALL equal (state==IDLE); CTRL.bit0 reads 1 when state!=IDLE.
REQ-020 Start write when state!=IDLE SHALL be ignored; PARAM writes when state!=IDLE SHALL be ignored (OKAY returned).
REQ-021 CTRL.done SHALL set on ACK entry and clear on the rdata capture of a CTRL read; if set and clear coincide, set wins; a new start also clears done.
REQ-022 Param channel: paramaddr_0a SHALL pulse one cycle when paramaddr_0r0=1 and paramdata_0r0=0; next cycle paramdata_0r0=1 with paramdata_0D=PARAM[paramaddr_0D] (0 if index>=NUM_PARAMS), held until paramdata_0a sampled high, then deasserted.
REQ-023 Param lookups SHALL be served in any FSM state; go/done path and AXI paths operate concurrently.

Reset
REQ-024 While reset=0: all PARAM registers and done=0, state=IDLE, and awready, wready, bvalid, arready, rvalid, go_0r, done_0a, paramaddr_0a, paramdata_0r0=0; rdata, paramdata_0D=0.
REQ-025 Reset asserted mid-transaction SHALL abandon all pending AXI responses and handshakes; no response is issued after release.

Verification
REQ-026 Write PARAM[2]=0xDEADBEEF, wstrb=4'b0011 over 0 -> read 0x18 returns 0x0000BEEF, bresp/rresp=0.
REQ-027 Write CTRL=1 -> go_0r=1 next cycle; go_0a=1 -> RUN; done_0r=1 -> done_0a=1 one cycle; CTRL read returns 0x6, second read 0x4.
REQ-028 PARAM[5]=0x1234 write, paramaddr_0r0=1 with paramaddr_0D=5 -> paramaddr_0a pulse, paramdata_0D=0x1234, paramdata_0r0 held for 3 cycles of paramdata_0a=0.
REQ-029 paramaddr_0D=NUM_PARAMS -> paramdata_0D=0; read of 0x04 returns 0; write to 0x0C has no effect.
REQ-030 bready held 0 for 5 cycles with awvalid/wvalid pending second write -> bvalid held, awready/wready stay 0 until first response accepted.
REQ-031 reset=0 asserted in RUN with rvalid=1 -> all outputs 0 immediately; after release CTRL reads 0x4.
